sw_debounce_bank: RTL and testbench
===================================

Name: sw_debounce_bank

Overview:
- Input-side conditioner for the board slide-switch bank. It turns raw, asynchronous, bouncing switch levels into clean, clock-synchronous levels.
- It also produces one-cycle edge pulses for each switch.
- It sits between the switch pins and downstream logic such as the NAND/NOR gate LED logic, counters and mode selects.
- The LED logic is the output end of the switch-to-LED path; this block is the input end.

Parameters:
- WIDTH, 4: number of switch bits handled, each bit independent.
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles a synchronized input must differ from the stable value before it is accepted. 1000000 cycles is 20 ms at 50 MHz. Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES): per-bit counter width. It is derived and must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sw_raw  input  WIDTH  raw switch levels, asynchronous to clk.
- sw_stable  output  WIDTH  debounced level per bit, registered.
- sw_rise  output  WIDTH  1-cycle pulse when sw_stable bit goes 0->1, registered.
- sw_fall  output  WIDTH  1-cycle pulse when sw_stable bit goes 1->0, registered.
- sw_changed  output  1  registered OR of all sw_rise and sw_fall bits.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - While rst_n=0, all registers are 0: sync stages, counters, sw_stable, sw_rise, sw_fall and sw_changed.
  - Reset mid-count discards all progress.
- Synchronizer: two flip-flop stages per bit, sync1 <= sw_raw and sync2 <= sync1. There is no logic between the stages.
- Per-bit state machine, two states:
  - IDLE: sync2 == sw_stable, cnt = 0.
  - COUNT: sync2 != sw_stable.
- Per-bit, at each clock edge:
  - If sync2 == sw_stable: cnt <= 0 and state becomes IDLE. Any bounce back restarts the count.
  - If sync2 != sw_stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1 and state is COUNT.
  - If sync2 != sw_stable and cnt == DEBOUNCE_CYCLES-1: sw_stable <= sync2, cnt <= 0, state becomes IDLE. sw_rise or sw_fall for that bit is set to 1 on the same edge.
- Pulses:
  - sw_rise and sw_fall are high for exactly one cycle and are 0 on every other cycle.
  - A bit's rise and fall are never high together.
  - sw_changed is registered on the same edge as the pulses, so it is coincident with them.
- Latency:
  - Raw change settles before edge k and stays steady.
  - sw_stable changes after edge k+1+DEBOUNCE_CYCLES.
  - Total latency is DEBOUNCE_CYCLES+2 edges counting edge k.
- Bits are fully independent. Simultaneous changes on several bits produce pulses on the same cycle if their timing matches.
- A glitch shorter than DEBOUNCE_CYCLES cycles, measured at sync2, never reaches sw_stable.
- Counter saturation cannot occur: the counter is cleared on acceptance.
- Switches already high at reset release: sw_stable rises DEBOUNCE_CYCLES+2 edges after release, with an sw_rise pulse. This is the intended power-up behaviour.

Decomposition:
- Shared package sw_pkg:
  - CLK_HZ = 50000000.
  - DEBOUNCE_MS = 20.
  - DEFAULT_DEBOUNCE_CYCLES = CLK_HZ/1000*DEBOUNCE_MS.
  - SW_WIDTH = 4.
- Sub-module debounce_bit: a single-bit synchronizer, counter and FSM with rise/fall outputs.
  - sw_debounce_bank instantiates it WIDTH times via generate and ORs the pulses into sw_changed.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Reset hold with sw_raw=4'b1010 -> all outputs 0 while rst_n=0. After release, sw_stable=4'b1010 after edge 6, with sw_rise=4'b1010 for 1 cycle and sw_changed=1 for 1 cycle.
- From stable 0, set sw_raw[0]=1 before edge k -> sw_stable[0]=1 after edge k+5, sw_rise[0] high exactly one cycle, sw_fall=0.
- Bounce: sw_raw[1] toggles 1,0,1 with 2-cycle high periods, then held 1 -> sw_stable[1] changes only 6 edges after the final settle, with one sw_rise[1] pulse.
- 3-cycle glitch on sw_raw[2] (0->1->0) -> sw_stable[2] stays 0, no pulses.
- All four bits fall together from 4'b1111 -> sw_stable=4'b0000 on the same edge, sw_fall=4'b1111 for one cycle, sw_changed=1.
- rst_n pulsed low while bit 3 is at cnt=2 -> all outputs 0 at once (asynchronous). After release, the count restarts from 0, giving full latency again.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants and types for the switch debounce bank
package sw_pkg;

   localparam int CLK_HZ                  = 50000000;
   localparam int DEBOUNCE_MS             = 20;
   localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
   localparam int SW_WIDTH                = 4;

   typedef enum logic {
      DB_IDLE  = 1'b0,
      DB_COUNT = 1'b1
   } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - single switch bit: two-stage synchronizer, hold counter, edge pulses
module debounce_bit
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o,
   output logic pulse_d_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   db_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             differ;

   assign differ = sync2_q ^ stable_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         state_q  <= DB_IDLE;
         cnt_q    <= '0;
         stable_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   // IDLE always holds cnt at zero, so the first differing edge loads 1 directly.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      unique case (state_q)
         DB_IDLE: begin
            if (differ) begin
               state_d = DB_COUNT;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         DB_COUNT: begin
            if (!differ) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d  = DB_IDLE;
               cnt_d    = '0;
               stable_d = sync2_q;
               rise_d   = sync2_q;
               fall_d   = ~sync2_q;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      stable_o  = stable_q;
      rise_o    = rise_q;
      fall_o    = fall_q;
      pulse_d_o = rise_d | fall_d;
   end

endmodule

// File: rtl/sw_debounce_bank.sv
// rtl/sw_debounce_bank.sv - bank of independent switch debouncers with a shared change pulse
module sw_debounce_bank
   import sw_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_stable,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   logic [WIDTH-1:0] pulse_d;
   logic             changed_q;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_bit (
         .clk       (clk),
         .rst_n     (rst_n),
         .raw_i     (sw_raw[i]),
         .stable_o  (sw_stable[i]),
         .rise_o    (sw_rise[i]),
         .fall_o    (sw_fall[i]),
         .pulse_d_o (pulse_d[i])
      );
   end

   // Built from the bits' next-state pulses so it lands on the same edge as them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) changed_q <= 1'b0;
      else        changed_q <= |pulse_d;
   end

   assign sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce_bank.sv
// tb/tb_sw_debounce_bank.sv - randomized and directed bench against a sample-history reference model
module tb_sw_debounce_bank;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sw_raw = '0;
   logic [W-1:0] sw_stable, sw_rise, sw_fall;
   logic         sw_changed;

   int n_checks = 0;
   int n_errors = 0;

   bit [W-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
   bit         m_chg;
   bit         hist[W][$];

   sw_debounce_bank #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (D)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw),
      .sw_stable  (sw_stable),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      for (int b = 0; b < W; b++) hist[b].delete();
   endtask

   // A bit is accepted once its last D synchronized samples all disagree with the stable level.
   task automatic model_step();
      bit all_diff;
      m_rise = '0;
      m_fall = '0;
      for (int b = 0; b < W; b++) begin
         hist[b].push_back(m_s2[b]);
         if (hist[b].size() > D) void'(hist[b].pop_front());
         all_diff = (hist[b].size() == D);
         for (int i = 0; i < hist[b].size(); i++)
            if (hist[b][i] == m_stable[b]) all_diff = 1'b0;
         if (all_diff) begin
            m_stable[b] = ~m_stable[b];
            if (m_stable[b]) m_rise[b] = 1'b1;
            else             m_fall[b] = 1'b1;
         end
      end
      m_chg = |(m_rise | m_fall);
      m_s2  = m_s1;
      m_s1  = sw_raw;
   endtask

   task automatic compare_all(input string tag);
      check_val({tag, "_stable"},  32'(sw_stable),  32'(m_stable));
      check_val({tag, "_rise"},    32'(sw_rise),    32'(m_rise));
      check_val({tag, "_fall"},    32'(sw_fall),    32'(m_fall));
      check_val({tag, "_changed"}, 32'(sw_changed), 32'(m_chg));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      compare_all("cyc");
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int idx;
      int rate;

      model_reset();
      sw_raw = 4'b1010;
      @(posedge clk); #1;
      compare_all("in_reset");
      @(posedge clk); #1;
      compare_all("in_reset2");
      #2;
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) check_val("t1_stable_e5", 32'(sw_stable), 32'h0);
         if (e == 6) begin
            check_val("t1_stable_e6", 32'(sw_stable), 32'ha);
            check_val("t1_rise_e6", 32'(sw_rise), 32'ha);
            check_val("t1_changed_e6", 32'(sw_changed), 32'h1);
         end
         if (e == 7) begin
            check_val("t1_rise_e7", 32'(sw_rise), 32'h0);
            check_val("t1_changed_e7", 32'(sw_changed), 32'h0);
         end
      end

      sw_raw = 4'b1011;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) check_val("t2_stable_e5", 32'(sw_stable), 32'ha);
         if (e == 6) begin
            check_val("t2_stable_e6", 32'(sw_stable), 32'hb);
            check_val("t2_rise_e6", 32'(sw_rise), 32'h1);
            check_val("t2_fall_e6", 32'(sw_fall), 32'h0);
         end
         if (e == 7) check_val("t2_rise_e7", 32'(sw_rise), 32'h0);
      end

      sw_raw = 4'b1001;
      ticks(8);
      sw_raw[1] = 1'b1; ticks(2);
      sw_raw[1] = 1'b0; ticks(2);
      sw_raw[1] = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 5) check_val("t3_stable1_e5", 32'(sw_stable[1]), 32'h0);
         if (e == 6) begin
            check_val("t3_stable1_e6", 32'(sw_stable[1]), 32'h1);
            check_val("t3_rise_e6", 32'(sw_rise), 32'h2);
         end
      end

      sw_raw[2] = 1'b1; ticks(3);
      sw_raw[2] = 1'b0; ticks(10);
      check_val("t4_glitch_stable2", 32'(sw_stable[2]), 32'h0);

      sw_raw = 4'b1111;
      ticks(8);
      check_val("t5_all_high", 32'(sw_stable), 32'hf);
      sw_raw = 4'b0000;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e == 6) begin
            check_val("t5_stable_e6", 32'(sw_stable), 32'h0);
            check_val("t5_fall_e6", 32'(sw_fall), 32'hf);
            check_val("t5_changed_e6", 32'(sw_changed), 32'h1);
         end
      end

      sw_raw = 4'b0111;
      ticks(8);
      sw_raw = 4'b1111;
      ticks(4);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("t6_async_stable", 32'(sw_stable), 32'h0);
      compare_all("t6_async");
      #2;
      rst_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         if (e == 5) check_val("t6_stable_e5", 32'(sw_stable), 32'h0);
         if (e == 6) begin
            check_val("t6_stable_e6", 32'(sw_stable), 32'hf);
            check_val("t6_rise_e6", 32'(sw_rise), 32'hf);
         end
      end

      rate = 4;
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 0) rate = int'($urandom_range(12, 2));
         if ($urandom_range(rate - 1) == 0) begin
            idx = int'($urandom_range(W - 1));
            sw_raw[idx] = ~sw_raw[idx];
         end
         if ($urandom_range(599) == 0) pulse_reset();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
